// File: rtl/muldiv_pkg.sv
// Shared types and constants for the HI/LO multiply/divide unit.
package muldiv_pkg;

  localparam int DATA_W = 32;

  typedef enum logic [1:0] {
    OP_MULT  = 2'b00,
    OP_MULTU = 2'b01,
    OP_DIV   = 2'b10,
    OP_DIVU  = 2'b11
  } op_e;

  typedef enum logic [1:0] {
    IDLE,
    CALC,
    FIX,
    DONE
  } state_e;

  // Two's-complement negate when neg is set, otherwise pass through.
  function automatic logic [DATA_W-1:0] cond_neg(input logic [DATA_W-1:0] x, input logic neg);
    return neg ? (~x + DATA_W'(1)) : x;
  endfunction

endpackage

// File: rtl/hilo_muldiv_if.sv
// Request/result bundle between a requester and the HI/LO multiply/divide unit.
interface hilo_muldiv_if;
  import muldiv_pkg::*;

  logic              start;
  logic [1:0]        op;
  logic [DATA_W-1:0] a;
  logic [DATA_W-1:0] b;
  logic              mthi;
  logic              mtlo;
  logic              busy;
  logic              done;
  logic [DATA_W-1:0] hi;
  logic [DATA_W-1:0] lo;

  modport master (output start, op, a, b, mthi, mtlo, input busy, done, hi, lo);
  modport slave  (input start, op, a, b, mthi, mtlo, output busy, done, hi, lo);

endinterface

// File: rtl/hilo_muldiv.sv
// Iterative 32-bit multiply/divide unit with architectural HI/LO registers.
// Operands are reduced to magnitudes on acceptance, iterated for 32 cycles
// through a single 33-bit adder, then sign-corrected in one FIX cycle.
module hilo_muldiv
  import muldiv_pkg::*;
(
  input  logic         clk,
  input  logic         reset,
  hilo_muldiv_if.slave bus
);

  state_e            state;
  state_e            state_next;
  logic [4:0]        count;
  logic              div_op;
  logic              neg_q;
  logic              neg_r;
  logic              div_zero;
  logic [DATA_W-1:0] acc;
  logic [DATA_W-1:0] mq;
  logic [DATA_W-1:0] b_mag;
  logic [DATA_W-1:0] a_raw;
  logic [DATA_W-1:0] hi_r;
  logic [DATA_W-1:0] lo_r;

  op_e               op_in;
  logic              in_signed;
  logic              in_div;

  logic [DATA_W:0]   add_a;
  logic [DATA_W:0]   add_b;
  logic              add_cin;
  logic [DATA_W+1:0] add_sum;

  logic [2*DATA_W-1:0] product;
  logic [2*DATA_W-1:0] product_fix;
  logic [DATA_W-1:0]   fix_hi;
  logic [DATA_W-1:0]   fix_lo;

  assign op_in     = op_e'(bus.op);
  assign in_signed = (op_in == OP_MULT) || (op_in == OP_DIV);
  assign in_div    = (op_in == OP_DIV)  || (op_in == OP_DIVU);

  assign bus.busy = (state == CALC) || (state == FIX);
  assign bus.done = (state == DONE);
  assign bus.hi   = hi_r;
  assign bus.lo   = lo_r;

  // Shared adder: add the multiplicand for multiply, subtract the divisor
  // (carry out = no borrow) for divide.
  always_comb begin
    add_a   = div_op ? {acc, mq[DATA_W-1]} : {1'b0, acc};
    add_b   = '0;
    add_cin = div_op;
    if (div_op) begin
      add_b = ~{1'b0, b_mag};
    end else if (mq[0]) begin
      add_b = {1'b0, b_mag};
    end
    add_sum = {1'b0, add_a} + {1'b0, add_b} + {{(DATA_W+1){1'b0}}, add_cin};
  end

  // Final sign correction and divide-by-zero override applied in FIX.
  always_comb begin
    fix_hi      = '0;
    fix_lo      = '0;
    product     = {acc, mq};
    product_fix = neg_q ? (~product + (2*DATA_W)'(1)) : product;
    if (!div_op) begin
      {fix_hi, fix_lo} = product_fix;
    end else if (div_zero) begin
      fix_hi = a_raw;
      fix_lo = '1;
    end else begin
      fix_hi = cond_neg(acc, neg_r);
      fix_lo = cond_neg(mq, neg_q);
    end
  end

  // State register.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) state <= IDLE;
    else       state <= state_next;
  end

  // Next-state logic: 32 CALC cycles bracketed by acceptance and one FIX cycle.
  always_comb begin
    state_next = state;
    case (state)
      IDLE:    if (bus.start) state_next = CALC;
      CALC:    if (count == 5'd31) state_next = FIX;
      FIX:     state_next = DONE;
      DONE:    state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  // Datapath: operand capture, iteration, result write-back and HI/LO moves.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      count    <= '0;
      div_op   <= 1'b0;
      neg_q    <= 1'b0;
      neg_r    <= 1'b0;
      div_zero <= 1'b0;
      acc      <= '0;
      mq       <= '0;
      b_mag    <= '0;
      a_raw    <= '0;
      hi_r     <= '0;
      lo_r     <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (bus.start) begin
            count    <= '0;
            div_op   <= in_div;
            neg_q    <= in_signed & (bus.a[DATA_W-1] ^ bus.b[DATA_W-1]);
            neg_r    <= in_signed & bus.a[DATA_W-1];
            div_zero <= (bus.b == '0);
            acc      <= '0;
            mq       <= cond_neg(bus.a, in_signed & bus.a[DATA_W-1]);
            b_mag    <= cond_neg(bus.b, in_signed & bus.b[DATA_W-1]);
            a_raw    <= bus.a;
          end else begin
            if (bus.mthi) hi_r <= bus.a;
            if (bus.mtlo) lo_r <= bus.a;
          end
        end
        CALC: begin
          count <= count + 5'd1;
          if (div_op) begin
            if (add_sum[DATA_W+1]) begin
              acc <= add_sum[DATA_W-1:0];
              mq  <= {mq[DATA_W-2:0], 1'b1};
            end else begin
              acc <= add_a[DATA_W-1:0];
              mq  <= {mq[DATA_W-2:0], 1'b0};
            end
          end else begin
            acc <= add_sum[DATA_W:1];
            mq  <= {add_sum[0], mq[DATA_W-1:1]};
          end
        end
        FIX: begin
          hi_r <= fix_hi;
          lo_r <= fix_lo;
        end
        default: ;
      endcase
    end
  end

endmodule
